// File: rtl/obf_key_bank.sv
// Run-time keyed bank of NCH obfuscation cells (pass/invert/force-1/force-0).
// Ports: clk, rst_n, key_sdi/key_shift/key_commit in; sig_in[NCH]; sig_out[NCH], key_sdo, key_valid, key_locked, key_err out.
module obf_key_bank #(
  parameter int         NCH            = 4,
  parameter int         OUT_REG        = 0,
  parameter int         LOCK_ON_COMMIT = 1,
  parameter logic [1:0] RESET_MODE     = 2'b11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_sdi,
  input  logic           key_shift,
  input  logic           key_commit,
  input  logic [NCH-1:0] sig_in,
  output logic [NCH-1:0] sig_out,
  output logic           key_sdo,
  output logic           key_valid,
  output logic           key_locked,
  output logic           key_err
);

  localparam int KL = 2 * NCH;
  localparam int CW = $clog2(KL + 2);

  localparam logic [CW-1:0] CNT_KL  = CW'(KL);
  localparam logic [CW-1:0] CNT_MAX = CW'(KL + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  logic [1:0]    state, state_d;
  logic [KL-1:0] shadow, shadow_d;
  logic [KL-1:0] active, active_d;
  logic [CW-1:0] count, count_d;
  logic          valid_d;
  logic          err_d;

  logic          locked;
  logic          do_both;
  logic          do_lock;
  logic          do_shift;
  logic          do_commit;

  assign locked = (state == S_LOCK);

  // Mutually exclusive request classes.
  assign do_both   = key_shift & key_commit;
  assign do_lock   = locked & (key_shift ^ key_commit);
  assign do_shift  = ~locked & key_shift & ~key_commit;
  assign do_commit = ~locked & key_commit & ~key_shift;

  always_comb begin
    state_d  = state;
    shadow_d = shadow;
    active_d = active;
    count_d  = count;
    valid_d  = key_valid;
    err_d    = 1'b0;
    unique case (1'b1)
      do_both: begin
        err_d = 1'b1;
      end
      do_lock: begin
        err_d = 1'b1;
      end
      do_shift: begin
        shadow_d = {shadow[KL-2:0], key_sdi};
        count_d  = (count == CNT_MAX) ?
                   count : count + 1'b1;
        state_d  = S_LOAD;
      end
      do_commit: begin
        count_d = '0;
        state_d = S_IDLE;
        if (state == S_LOAD &&
            count == CNT_KL) begin
          active_d = shadow;
          valid_d  = 1'b1;
          if (LOCK_ON_COMMIT != 0)
            state_d = S_LOCK;
        end else begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shadow    <= '0;
      active    <= {NCH{RESET_MODE}};
      count     <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      state     <= state_d;
      shadow    <= shadow_d;
      active    <= active_d;
      count     <= count_d;
      key_valid <= valid_d;
      key_err   <= err_d;
    end
  end

  logic [NCH-1:0] sig_mix;

  always_comb begin
    sig_mix = '0;
    for (int k = 0; k < NCH; k++) begin
      unique case (active[2*k +: 2])
        2'b00:   sig_mix[k] = sig_in[k];
        2'b01:   sig_mix[k] = ~sig_in[k];
        2'b10:   sig_mix[k] = 1'b1;
        default: sig_mix[k] = 1'b0;
      endcase
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [NCH-1:0] sig_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_mix;
      end
      assign sig_out = sig_q;
    end else begin : g_comb
      assign sig_out = sig_mix;
    end
  endgenerate

  assign key_sdo    = shadow[KL-1];
  assign key_locked = locked;

endmodule

// File: tb/tb_obf_key_bank.sv
// Bench for obf_key_bank: two instances (locking/comb and relocking/registered)
// checked every cycle against a bench model plus literal expectations.
module tb_obf_key_bank;

  logic       clk;
  logic       rst_n;
  logic       key_sdi;
  logic       key_shift;
  logic       key_commit;
  logic [3:0] sig_in;

  logic [3:0] so0, so1;
  logic       sdo0, sdo1;
  logic       val0, val1;
  logic       lck0, lck1;
  logic       err0, err1;

  int errors = 0;
  int checks = 0;

  obf_key_bank #(
    .NCH(4), .OUT_REG(0), .LOCK_ON_COMMIT(1), .RESET_MODE(2'b11)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .key_sdi(key_sdi),
    .key_shift(key_shift), .key_commit(key_commit),
    .sig_in(sig_in), .sig_out(so0), .key_sdo(sdo0),
    .key_valid(val0), .key_locked(lck0), .key_err(err0)
  );

  obf_key_bank #(
    .NCH(4), .OUT_REG(1), .LOCK_ON_COMMIT(0), .RESET_MODE(2'b11)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .key_sdi(key_sdi),
    .key_shift(key_shift), .key_commit(key_commit),
    .sig_in(sig_in), .sig_out(so1), .key_sdo(sdo1),
    .key_valid(val1), .key_locked(lck1), .key_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Model: last 8 shifted bits, bits-since-commit, per-channel modes.
  logic [7:0] m_sh[2];
  int         m_cnt[2];
  logic [1:0] m_mode[2][4];
  logic       m_lock[2];
  logic       m_val[2];
  logic       m_err[2];
  logic [3:0] m_q[2];

  function automatic logic [3:0] apply(input int i, input logic [3:0] in);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) begin
      case (m_mode[i][k])
        2'd0:    r[k] = in[k];
        2'd1:    r[k] = ~in[k];
        2'd2:    r[k] = 1'b1;
        default: r[k] = 1'b0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_sh[i]   <= '0;
        m_cnt[i]  <= 0;
        m_lock[i] <= 1'b0;
        m_val[i]  <= 1'b0;
        m_err[i]  <= 1'b0;
        m_q[i]    <= '0;
        for (int k = 0; k < 4; k++) m_mode[i][k] <= 2'd3;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_q[i]   <= apply(i, sig_in);
        m_err[i] <= 1'b0;
        if (key_shift && key_commit) begin
          m_err[i] <= 1'b1;
        end else if (m_lock[i]) begin
          if (key_shift || key_commit) m_err[i] <= 1'b1;
        end else if (key_shift) begin
          m_sh[i]  <= {m_sh[i][6:0], key_sdi};
          m_cnt[i] <= (m_cnt[i] >= 9) ? 9 : m_cnt[i] + 1;
        end else if (key_commit) begin
          if (m_cnt[i] == 8) begin
            for (int k = 0; k < 4; k++)
              m_mode[i][k] <= m_sh[i][2*k +: 2];
            m_val[i]  <= 1'b1;
            m_lock[i] <= (i == 0);
          end else begin
            m_err[i] <= 1'b1;
          end
          m_cnt[i] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("u0.sig_out", 32'(so0), 32'(apply(0, sig_in)));
    chk("u0.key_sdo", 32'(sdo0), 32'(m_sh[0][7]));
    chk("u0.key_valid", 32'(val0), 32'(m_val[0]));
    chk("u0.key_locked", 32'(lck0), 32'(m_lock[0]));
    chk("u0.key_err", 32'(err0), 32'(m_err[0]));
    chk("u1.sig_out", 32'(so1), 32'(m_q[1]));
    chk("u1.key_sdo", 32'(sdo1), 32'(m_sh[1][7]));
    chk("u1.key_valid", 32'(val1), 32'(m_val[1]));
    chk("u1.key_locked", 32'(lck1), 32'(m_lock[1]));
    chk("u1.key_err", 32'(err1), 32'(m_err[1]));
  end

  task automatic step(input logic sh, input logic cm, input logic sd);
    key_shift  = sh;
    key_commit = cm;
    key_sdi    = sd;
    @(posedge clk);
    #1;
    key_shift  = 1'b0;
    key_commit = 1'b0;
    key_sdi    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic shift_bits(input logic [7:0] k, input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = (i < 8) ? k[7-i] : 1'b0;
      step(1'b1, 1'b0, b);
    end
  endtask

  logic [7:0] key_a;
  logic [7:0] key_b;
  logic [7:0] key_c;

  initial begin
    key_a      = 8'b00_01_10_11;
    key_b      = 8'b01_01_01_01;
    key_c      = 8'b00_00_00_00;
    rst_n      = 1'b0;
    key_sdi    = 1'b0;
    key_shift  = 1'b0;
    key_commit = 1'b0;
    sig_in     = 4'b1010;
    repeat (3) @(posedge clk);
    #1;
    chk("rst u0 sig_out", 32'(so0), 32'h0);
    chk("rst u1 sig_out", 32'(so1), 32'h0);
    chk("rst valid", 32'(val0), 32'h0);
    chk("rst locked", 32'(lck0), 32'h0);
    chk("rst err", 32'(err0), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // short key
    shift_bits(key_a, 7);
    step(1'b0, 1'b1, 1'b0);
    chk("short err", 32'(err0), 32'h1);
    chk("short valid", 32'(val0), 32'h0);
    idle(1);
    chk("short err drop", 32'(err0), 32'h0);
    chk("short sig_out", 32'(so0), 32'h0);

    // overshift
    shift_bits(key_a, 9);
    step(1'b0, 1'b1, 1'b0);
    chk("over err", 32'(err1), 32'h1);
    chk("over locked", 32'(lck0), 32'h0);
    idle(1);

    // good key A
    shift_bits(key_a, 8);
    step(1'b0, 1'b1, 1'b0);
    chk("A u0 sig_out", 32'(so0), 32'he);
    chk("A u0 valid", 32'(val0), 32'h1);
    chk("A u0 locked", 32'(lck0), 32'h1);
    chk("A u1 locked", 32'(lck1), 32'h0);
    chk("A u1 sig_out old", 32'(so1), 32'h0);
    idle(1);
    chk("A u1 sig_out", 32'(so1), 32'he);

    // key B: u0 locked, u1 re-keys
    step(1'b1, 1'b0, key_b[7]);
    chk("lock shift err", 32'(err0), 32'h1);
    chk("unlock shift ok", 32'(err1), 32'h0);
    for (int i = 6; i >= 0; i--) step(1'b1, 1'b0, key_b[i]);
    chk("lock err held", 32'(err0), 32'h1);
    step(1'b0, 1'b1, 1'b0);
    chk("lock commit err", 32'(err0), 32'h1);
    idle(1);
    chk("B u0 sig_out", 32'(so0), 32'he);
    chk("B u1 sig_out", 32'(so1), 32'h5);

    // simultaneous shift+commit must not disturb count
    shift_bits(key_c, 4);
    step(1'b1, 1'b1, 1'b1);
    chk("both err", 32'(err1), 32'h1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("C commit ok", 32'(err1), 32'h0);
    idle(1);
    chk("C u1 sig_out", 32'(so1), 32'ha);

    // data toggling
    sig_in = 4'b0110;
    idle(1);
    chk("tog u1", 32'(so1), 32'h6);
    chk("tog u0", 32'(so0), 32'h2);
    for (int i = 0; i < 10; i++) begin
      sig_in = 4'($urandom_range(0, 15));
      idle(1);
    end

    // reset mid-load
    shift_bits(key_a, 5);
    rst_n = 1'b0;
    #2;
    chk("mid rst valid", 32'(val0), 32'h0);
    chk("mid rst locked", 32'(lck0), 32'h0);
    chk("mid rst sig_out", 32'(so0), 32'h0);
    chk("mid rst sdo", 32'(sdo1), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    shift_bits(key_a, 8);
    step(1'b0, 1'b1, 1'b0);
    chk("post rst commit err", 32'(err1), 32'h0);
    chk("post rst valid", 32'(val1), 32'h1);
    idle(2);
    chk("post rst u1 sig_out", 32'(so1), 32'(apply(1, sig_in)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
